// File: rtl/mux_nto1_reg_pkg.sv
// Shared defaults, mode encoding and select-width helper for the registered N-to-1 mux.
package mux_nto1_reg_pkg;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_DWELL    = 3;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

    // Ceiling log2, never below 1 so that a 1-entry range still gets a real bit.
    function automatic int mux_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_nto1_reg_scan_ctr.sv
// Auto-scan dwell counter with clear and terminal count, plus the modulo-CHANNELS select incrementer.
module mux_scan_ctr
    import mux_nto1_reg_pkg::*;
#(
    parameter int DWELL    = DEF_DWELL,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = mux_clog2(CHANNELS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    output logic             tc_o,
    input  logic [SEL_W-1:0] sel_i,
    output logic [SEL_W-1:0] sel_inc_o
);

    localparam int CNT_W = mux_clog2(DWELL);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc_o = (cnt_q == CNT_W'(DWELL - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tc_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_d;
        end
    end

    // Wrap is compared against CHANNELS-1 so non-power-of-two channel counts skip unused codes.
    assign sel_inc_o = (sel_i == SEL_W'(CHANNELS - 1)) ? '0 : sel_i + 1'b1;

endmodule

// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 mux with range-checked select register and auto-scan mode.
// Optional macro MUX_BREAK_BEFORE_MAKE_EN inserts one blanking cycle after each select change.
module mux_nto1_reg
    import mux_nto1_reg_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DWELL    = DEF_DWELL,
    parameter int SEL_W    = mux_clog2(CHANNELS)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      en_i,
    input  logic                      auto_i,
    input  logic                      sel_load_i,
    input  logic [SEL_W-1:0]          sel_i,
    input  logic [CHANNELS*WIDTH-1:0] d_i,
    output logic [WIDTH-1:0]          out_o,
    output logic                      out_valid_o,
    output logic [SEL_W-1:0]          sel_active_o,
    output logic                      err_o
);

    mode_e              mode;
    logic [WIDTH-1:0]   chan [CHANNELS];
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   sel_d;
    logic [SEL_W-1:0]   sel_inc;
    logic [WIDTH-1:0]   out_q;
    logic               valid_q;
    logic               err_q;
    logic               err_d;
    logic               load_ok;
    logic               advance;
    logic               tc;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            assign chan[gi] = d_i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign mode    = auto_i ? MODE_AUTO : MODE_MANUAL;
    assign load_ok = sel_load_i && ({1'b0, sel_i} < (SEL_W + 1)'(CHANNELS));
    // A valid load wins over auto-advance; an invalid one leaves the scan untouched.
    assign advance = (mode == MODE_AUTO) && !load_ok && tc;
    assign err_d   = sel_load_i && !load_ok;

    always_comb begin
        sel_d = sel_q;
        if (load_ok) begin
            sel_d = sel_i;
        end else if (advance) begin
            sel_d = sel_inc;
        end
    end

    mux_scan_ctr #(
        .DWELL    (DWELL),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_scan_ctr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en_i      (en_i),
        .clr_i     ((mode == MODE_MANUAL) || load_ok),
        .tc_o      (tc),
        .sel_i     (sel_q),
        .sel_inc_o (sel_inc)
    );

`ifdef MUX_BREAK_BEFORE_MAKE_EN
    logic blank_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            blank_q <= 1'b0;
        end else if (!en_i) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            err_q   <= err_d;
            blank_q <= (sel_d != sel_q);
            if (blank_q) begin
                out_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                out_q   <= chan[sel_q];
                valid_q <= 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (!en_i) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            err_q   <= err_d;
            out_q   <= chan[sel_q];
            valid_q <= 1'b1;
        end
    end
`endif

    assign out_o        = out_q;
    assign out_valid_o  = valid_q;
    assign sel_active_o = sel_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Self-checking bench for mux_nto1_reg: 4-channel table-driven vectors plus a 3-channel range-error sequence.
module tb_mux_nto1_reg;

    typedef struct {
        logic        en;
        logic        am;
        logic        ld;
        logic [1:0]  sel;
        logic [15:0] d;
        logic [3:0]  out;
        logic        v;
        logic [1:0]  sa;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        am;
    logic        ld;
    logic [1:0]  sel;
    logic [15:0] d;
    logic [3:0]  out;
    logic        out_v;
    logic [1:0]  sa;
    logic        err;

    logic        am3;
    logic        ld3;
    logic [1:0]  sel3;
    logic [11:0] d3;
    logic [3:0]  out3;
    logic        out_v3;
    logic [1:0]  sa3;
    logic        err3;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mux_nto1_reg #(.WIDTH(4), .CHANNELS(4), .DWELL(3), .SEL_W(2)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .auto_i(am), .sel_load_i(ld),
        .sel_i(sel), .d_i(d), .out_o(out), .out_valid_o(out_v),
        .sel_active_o(sa), .err_o(err)
    );

    mux_nto1_reg #(.WIDTH(4), .CHANNELS(3), .DWELL(3), .SEL_W(2)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .auto_i(am3), .sel_load_i(ld3),
        .sel_i(sel3), .d_i(d3), .out_o(out3), .out_valid_o(out_v3),
        .sel_active_o(sa3), .err_o(err3)
    );

    function automatic vec_t mk(input logic e, input logic a, input logic l, input logic [1:0] s,
                                input logic [15:0] dd, input logic [3:0] o, input logic vv,
                                input logic [1:0] ss, input logic er);
        vec_t r;
        r.en = e; r.am = a; r.ld = l; r.sel = s; r.d = dd;
        r.out = o; r.v = vv; r.sa = ss; r.err = er;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chk4(input string tag, input logic [3:0] o, input logic vv,
                        input logic [1:0] ss, input logic er);
        chk({tag, ".out"},   {12'h0, out},   {12'h0, o});
        chk({tag, ".valid"}, {15'h0, out_v}, {15'h0, vv});
        chk({tag, ".sel"},   {14'h0, sa},    {14'h0, ss});
        chk({tag, ".err"},   {15'h0, err},   {15'h0, er});
    endtask

    task automatic chk3(input string tag, input logic [3:0] o, input logic [1:0] ss, input logic er);
        chk({tag, ".out3"}, {12'h0, out3}, {12'h0, o});
        chk({tag, ".sel3"}, {14'h0, sa3},  {14'h0, ss});
        chk({tag, ".err3"}, {15'h0, err3}, {15'h0, er});
        $display("%s: out3=%h sel3=%0d err3=%b", tag, out3, sa3, err3);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; am = 1'b0; ld = 1'b0; sel = 2'd0; d = 16'hDCBA;
        am3 = 1'b0; ld3 = 1'b0; sel3 = 2'd0; d3 = 12'h987;
        step();
        step();
        chk4("reset", 4'h0, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;
        en    = 1'b1;

`ifndef MUX_BREAK_BEFORE_MAKE_EN
        // en, auto, load, sel, d  ->  out, valid, sel_active, err (after the edge)
        vecs.push_back(mk(1, 0, 0, 0, 16'hDCBA, 4'hA, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 2, 16'hDCBA, 4'hA, 1, 2, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'hDCBA, 4'hC, 1, 2, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'hD5BA, 4'h5, 1, 2, 0));
        vecs.push_back(mk(1, 0, 1, 3, 16'hDCBA, 4'hC, 1, 3, 0));
        vecs.push_back(mk(1, 0, 1, 0, 16'hDCBA, 4'hD, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'hDCBA, 4'hD, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'hDCBA, 4'hA, 1, 0, 0));
        // auto-scan wrap over 12 cycles
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hA, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hA, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hA, 1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hB, 1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hB, 1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hB, 1, 2, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hC, 1, 2, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hC, 1, 2, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hC, 1, 3, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hD, 1, 3, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hD, 1, 3, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hD, 1, 0, 0));
        // load in auto beats advance and restarts the dwell
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hA, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 3, 16'hDCBA, 4'hA, 1, 3, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hD, 1, 3, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hD, 1, 3, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hD, 1, 0, 0));
        // freeze for 5 cycles
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, 0, 0, 16'hDCBA, 4'hD, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hA, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hA, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hA, 1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hB, 1, 1, 0));
        // auto 1->0 with count mid-dwell: select holds, count clears
        vecs.push_back(mk(1, 0, 0, 0, 16'hDCBA, 4'hB, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'hDCBA, 4'hB, 1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hB, 1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hB, 1, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 16'hDCBA, 4'hB, 1, 2, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'hDCBA, 4'hC, 1, 2, 0));

        foreach (vecs[i]) begin
            en = vecs[i].en; am = vecs[i].am; ld = vecs[i].ld; sel = vecs[i].sel; d = vecs[i].d;
            step();
            $display("vec %0d: out=%h valid=%b sel=%0d err=%b", i, out, out_v, sa, err);
            chk4($sformatf("vec%0d", i), vecs[i].out, vecs[i].v, vecs[i].sa, vecs[i].err);
        end

        // asynchronous reset mid-cycle, no clock edge
        en = 1'b1; am = 1'b0; ld = 1'b0;
        #3 rst_n = 1'b0;
        #1 chk4("async_reset", 4'h0, 1'b0, 2'd0, 1'b0);
        $display("async_reset: out=%h valid=%b sel=%0d", out, out_v, sa);
        #1 rst_n = 1'b1;
        step();
        chk4("post_reset", 4'hA, 1'b1, 2'd0, 1'b0);
        $display("post_reset: out=%h valid=%b sel=%0d", out, out_v, sa);

        // 3-channel instance: range error and non-power-of-two wrap
        ld3 = 1'b1; sel3 = 2'd2; step(); chk3("r3_load2", 4'h7, 2'd2, 1'b0);
        ld3 = 1'b0;              step(); chk3("r3_hold",  4'h9, 2'd2, 1'b0);
        ld3 = 1'b1; sel3 = 2'd3; step(); chk3("r3_bad",   4'h9, 2'd2, 1'b1);
        ld3 = 1'b0;              step(); chk3("r3_clr",   4'h9, 2'd2, 1'b0);
        am3 = 1'b1;              step(); chk3("r3_a1",    4'h9, 2'd2, 1'b0);
                                 step(); chk3("r3_a2",    4'h9, 2'd2, 1'b0);
        ld3 = 1'b1; sel3 = 2'd3; step(); chk3("r3_badwrap", 4'h9, 2'd0, 1'b1);
        ld3 = 1'b0; am3 = 1'b0;  step(); chk3("r3_after", 4'h7, 2'd0, 1'b0);
`else
        step(); chk4("bbm_idle", 4'hA, 1'b1, 2'd0, 1'b0);
        ld = 1'b1; sel = 2'd3;
        step(); chk4("bbm_load3", 4'hA, 1'b1, 2'd3, 1'b0);
        ld = 1'b0;
        step(); chk4("bbm_blank", 4'h0, 1'b0, 2'd3, 1'b0);
        step(); chk4("bbm_make", 4'hD, 1'b1, 2'd3, 1'b0);
        ld = 1'b1; sel = 2'd3;
        step(); chk4("bbm_reload", 4'hD, 1'b1, 2'd3, 1'b0);
        ld = 1'b0;
        step(); chk4("bbm_noblank", 4'hD, 1'b1, 2'd3, 1'b0);
        $display("bbm: out=%h valid=%b sel=%0d", out, out_v, sa);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_nto1_reg.md
Name: mux_nto1_reg

Overview:
Parametrised, registered N-to-1 multiplexer; generalises the 2-to-1 select primitive to CHANNELS inputs of WIDTH bits each.
- Adds a latched select register with range checking.
- Adds an auto-scan mode that cycles through channels on a programmable dwell count.
- Used by the microwave control path to route display/timer/keypad sources onto one shared bus.

Parameters:
WIDTH, 4, bit width of each data channel and of OUT
CHANNELS, 4, number of input channels (2..16)
DWELL, 3, cycles each channel is held in auto-scan mode (>=1)
SEL_W, 2, select width; must satisfy 2**SEL_W >= CHANNELS

Ports:
CLK  input  1  single clock, rising-edge
RST_N  input  1  reset
EN  input  1  clock enable; 0 freezes all state
AUTO  input  1  1 = auto-scan mode, 0 = manual select
SEL_LOAD  input  1  strobe: load SEL into select register
SEL  input  SEL_W  requested channel index
D  input  CHANNELS*WIDTH  flattened data; channel i = D[i*WIDTH +: WIDTH]
OUT  output  WIDTH  registered selected data
OUT_VALID  output  1  OUT holds valid data of SEL_ACTIVE channel
SEL_ACTIVE  output  SEL_W  current select register value
ERR  output  1  one-cycle pulse: out-of-range SEL_LOAD rejected

Interface decision: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (RST_N=0, async): OUT=0, OUT_VALID=0, SEL_ACTIVE=0, ERR=0, dwell counter=0. Release takes effect at the next CLK edge.
- All updates occur at CLK rising edge and only when EN=1.
  - EN=0: all registers hold, OUT_VALID is forced to 0 on that edge, ERR=0.
- Data path: OUT <= channel[SEL_ACTIVE] every enabled edge. OUT_VALID <= 1 on every enabled edge (subject to break-before-make below).
- Latency:
  - D change to OUT: 1 cycle.
  - SEL_LOAD sampled at edge k → SEL_ACTIVE updates at k → OUT shows the new channel at k+1.
- Manual load:
  - SEL_LOAD=1 with SEL<CHANNELS: SEL_ACTIVE<=SEL and dwell counter<=0.
  - SEL_LOAD=1 with SEL>=CHANNELS: SEL_ACTIVE unchanged, ERR<=1 for exactly one cycle.
- Auto-scan (AUTO=1):
  - Dwell counter counts 0..DWELL-1.
  - At DWELL-1: counter<=0 and SEL_ACTIVE<=(SEL_ACTIVE+1) mod CHANNELS. The wrap from CHANNELS-1 to 0 is explicit and is not a power-of-2 wrap.
- Simultaneous events:
  - A valid SEL_LOAD in AUTO has priority over auto-advance; it loads SEL and restarts the dwell count.
  - An invalid SEL_LOAD in AUTO pulses ERR; auto-advance proceeds normally that cycle.
- AUTO 1→0: SEL_ACTIVE holds at its current value; the dwell counter clears.
- AUTO=0: the dwell counter stays 0.
- Reset mid-scan: returns to channel 0, counter 0, OUT_VALID=0.

Optional Feature:
Macro MUX_BREAK_BEFORE_MAKE_EN.
- Defined: on any edge where SEL_ACTIVE changes value, the following enabled edge drives OUT<=0 and OUT_VALID<=0 (one blanking cycle). The new channel appears one cycle later, so select-to-data latency is 2 cycles. Reloading the same index is not a change and causes no blanking.
- Undefined: no blanking; latency as stated in Behaviour.

Decomposition:
- Shared include mux_defs.vh holds:
  - default WIDTH/CHANNELS/DWELL constants;
  - a clog2 function macro for SEL_W;
  - the mode encodings MODE_MANUAL=0 and MODE_AUTO=1.
- One sub-module, mux_scan_ctr: DWELL counter with enable, clear and terminal-count output, and the modulo-CHANNELS select incrementer.
- The top level holds the select register, range check, output register and the optional blanking logic.

Test Plan:
All scenarios use WIDTH=4, CHANNELS=4, DWELL=3.
- Reset: assert RST_N=0 mid-cycle → OUT=0, OUT_VALID=0, SEL_ACTIVE=0 immediately without a clock edge; release, D={4'hD,4'hC,4'hB,4'hA}, EN=1 → next edge OUT=4'hA, OUT_VALID=1.
- Manual select: SEL_LOAD=1, SEL=2 at edge k → SEL_ACTIVE=2 after k, OUT=4'hC after k+1; change channel 2 to 4'h5 → OUT=4'h5 one cycle later.
- Range error: build with CHANNELS=3, SEL_LOAD=1, SEL=3 → ERR high exactly one cycle, SEL_ACTIVE unchanged, OUT unchanged.
- Auto-scan wrap: AUTO=1 from SEL_ACTIVE=0, EN=1 for 12 cycles → SEL_ACTIVE sequence 0,0,0,1,1,1,2,2,2,3,3,3 then 0; OUT follows one cycle behind.
- Priority/freeze: in AUTO, SEL_LOAD SEL=1 on dwell count 2 → SEL_ACTIVE=1 with count restarted (three full cycles on 1). Then EN=0 for 5 cycles → OUT and SEL_ACTIVE hold, OUT_VALID=0.
- MUX_BREAK_BEFORE_MAKE_EN build: switch 0→3 → one cycle OUT=0 with OUT_VALID=0, then OUT=4'hD with OUT_VALID=1. Reload SEL=3 → no blanking.
